board_mem_arbiter: RTL

- Shares the single-port synchronous Minesweeper board RAM between three requesters: CPU (lw/sw/bid accesses, port 0), VGA renderer (cell fetch, port 1) and input/cursor handler (cell reveal/flag writes, port 2).
- Grants at most one access per cycle using a rotating priority.
- Drives the RAM directly and returns read data tagged to the owner.
- Produces the CPU stall used by the pipeline when the CPU loses arbitration.

---
 rtl/board_mem_arbiter_if.sv | 33 +++
 rtl/board_mem_arbiter.sv | 111 +++++++++++
 2 files changed

// File: rtl/board_mem_arbiter_if.sv
// Board RAM sharing bus: three requester ports, grant/read-return signals and the RAM-side drive.
// The slave modport is the arbiter's view; master is the requesters plus RAM.
interface board_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NREQ   = 3
);
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   we;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [ADDR_W-1:0] addr2;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata2;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   rvalid;
  logic [DATA_W-1:0] rdata;
  logic              cpu_stall;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req, we, addr0, addr1, addr2, wdata0, wdata2, mem_rdata,
    output gnt, rvalid, rdata, cpu_stall, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output req, we, addr0, addr1, addr2, wdata0, wdata2, mem_rdata,
    input  gnt, rvalid, rdata, cpu_stall, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/board_mem_arbiter.sv
// Rotating-priority arbiter for the single-port Minesweeper board RAM shared by CPU (0),
// VGA renderer (1, read-only) and input/cursor handler (2); returns tagged read data.
module board_mem_arbiter #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NREQ   = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  board_mem_arbiter_if.slave    bus
);

  localparam int unsigned PTR_W = 2;
  // Ports allowed to write; the VGA port's we is ignored.
  localparam logic [NREQ-1:0] WR_CAPABLE = NREQ'(3'b101);

  logic [PTR_W-1:0]  ptr_q;
  logic [PTR_W-1:0]  ptr_d;
  logic [NREQ-1:0]   rvalid_q;
  logic [NREQ-1:0]   rvalid_d;

  logic [NREQ-1:0]   gnt_c;
  logic [PTR_W-1:0]  gnt_idx_c;
  logic              gnt_any_c;
  logic [PTR_W-1:0]  scan_c;

  logic [ADDR_W-1:0] mem_addr_c;
  logic              mem_we_c;
  logic [DATA_W-1:0] mem_wdata_c;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] i);
    return (i >= PTR_W'(2)) ? PTR_W'(0) : PTR_W'(i + PTR_W'(1));
  endfunction

  // First requester found scanning ptr, ptr+1, ptr+2 (mod 3) wins.
  always_comb begin
    gnt_c     = '0;
    gnt_idx_c = '0;
    gnt_any_c = 1'b0;
    scan_c    = ptr_q;
    for (int k = 0; k < 3; k++) begin
      if (!gnt_any_c && bus.req[scan_c]) begin
        gnt_any_c = 1'b1;
        gnt_idx_c = scan_c;
      end
      scan_c = wrap_inc(scan_c);
    end
    if (gnt_any_c) begin
      gnt_c[gnt_idx_c] = 1'b1;
    end
  end

  // RAM drive follows the owner; all zero when idle.
  always_comb begin
    mem_addr_c  = '0;
    mem_we_c    = 1'b0;
    mem_wdata_c = '0;
    if (gnt_any_c) begin
      case (gnt_idx_c)
        2'd0: begin
          mem_addr_c  = bus.addr0;
          mem_we_c    = bus.we[0];
          mem_wdata_c = bus.wdata0;
        end
        2'd1: begin
          mem_addr_c  = bus.addr1;
        end
        2'd2: begin
          mem_addr_c  = bus.addr2;
          mem_we_c    = bus.we[2];
          mem_wdata_c = bus.wdata2;
        end
        default: begin
          mem_addr_c  = '0;
        end
      endcase
    end
  end

  always_comb begin
    ptr_d    = ptr_q;
    rvalid_d = gnt_c & ~(bus.we & WR_CAPABLE);
    if (gnt_any_c) begin
      ptr_d = wrap_inc(gnt_idx_c);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q    <= '0;
      rvalid_q <= '0;
    end else begin
      ptr_q    <= ptr_d;
      rvalid_q <= rvalid_d;
    end
  end

  // Reset in the return cycle hides a pending pulse so the requester re-issues.
  assign bus.rvalid    = reset ? '0 : rvalid_q;
  assign bus.rdata     = (|bus.rvalid) ? bus.mem_rdata : '0;
  assign bus.gnt       = gnt_c;
  assign bus.cpu_stall = bus.req[0] & ~gnt_c[0];
  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_we    = mem_we_c;
  assign bus.mem_wdata = mem_wdata_c;

  a_gnt_onehot: assert property (@(posedge clock) $onehot0(bus.gnt));
  a_ptr_range:  assert property (@(posedge clock) ptr_q != PTR_W'(3));
  a_rvalid_oh:  assert property (@(posedge clock) $onehot0(bus.rvalid));

endmodule
